// File: rtl/serial_add_arbiter_if.sv
// serial_add_arbiter_if: request/grant/result bus between two clients and the serial adder
interface serial_add_arbiter_if #(parameter int WIDTH = 8);
    logic             req0, req1, gnt0, gnt1, done0, done1, busy;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [WIDTH:0]   sum;
    modport master (output req0, a0, b0, req1, a1, b1, input gnt0, gnt1, done0, done1, sum, busy);
    modport slave (input req0, a0, b0, req1, a1, b1, output gnt0, gnt1, done0, done1, sum, busy);
endinterface

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: one bit-serial full adder shared round-robin between two requesters
module serial_add_arbiter #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    serial_add_arbiter_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-2:0] res;
    logic [CW-1:0] cnt;
    logic carry, last, win1, s, co;
    // last holds the requester served most recently; reset value 1 favours requester 0
    assign win1 = bus.req1 & (~bus.req0 | ~last);
    assign s = ra[0] ^ rb[0] ^ carry;
    assign co = (ra[0] & rb[0]) | (carry & (ra[0] ^ rb[0]));
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ra <= '0;
            rb <= '0;
            res <= '0;
            cnt <= '0;
            carry <= 1'b0;
            last <= 1'b1;
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            bus.busy <= 1'b0;
            bus.sum <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req0 | bus.req1) begin
                    state <= SHIFT;
                    ra <= win1 ? bus.a1 : bus.a0;
                    rb <= win1 ? bus.b1 : bus.b0;
                    carry <= 1'b0;
                    cnt <= '0;
                    last <= win1;
                    bus.gnt0 <= ~win1;
                    bus.gnt1 <= win1;
                    bus.busy <= 1'b1;
                end
                SHIFT: begin
                    res <= {s, res[WIDTH-2:1]};
                    carry <= co;
                    ra <= ra >> 1;
                    rb <= rb >> 1;
                    cnt <= cnt + 1'b1;
                    // final bit bypasses res straight into the result
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        bus.sum <= {co, s, res};
                        bus.done0 <= bus.gnt0;
                        bus.done1 <= bus.gnt1;
                    end
                end
                default: begin
                    state <= IDLE;
                    bus.gnt0 <= 1'b0;
                    bus.gnt1 <= 1'b0;
                    bus.done0 <= 1'b0;
                    bus.done1 <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb_serial_add_arbiter: directed scenarios plus random traffic against a transaction-level timing model
module tb_serial_add_arbiter;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int left = 0;
    int owner = 0;
    int last = 1;
    logic [W:0] pend = '0;
    logic [W:0] exp_sum = '0;
    serial_add_arbiter_if #(.WIDTH(W)) bus();
    serial_add_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask
    // model: an operation occupies gnt for W+1 cycles, sum lands on entry to the last one
    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst) begin
            left = 0;
            last = 1;
            exp_sum = '0;
        end else if (left > 0) begin
            left--;
            if (left == 1) exp_sum = pend;
        end else if (bus.req0 || bus.req1) begin
            owner = (bus.req0 && bus.req1) ? 1 - last : (bus.req1 ? 1 : 0);
            last = owner;
            pend = owner == 1 ? (W+1)'(bus.a1) + (W+1)'(bus.b1) : (W+1)'(bus.a0) + (W+1)'(bus.b0);
            left = W + 1;
        end
        @(negedge clk);
        check("gnt0", 32'(bus.gnt0), 32'(left > 0 && owner == 0));
        check("gnt1", 32'(bus.gnt1), 32'(left > 0 && owner == 1));
        check("done0", 32'(bus.done0), 32'(left == 1 && owner == 0));
        check("done1", 32'(bus.done1), 32'(left == 1 && owner == 1));
        check("busy", 32'(bus.busy), 32'(left > 0));
        check("sum", 32'(bus.sum), 32'(exp_sum));
    endtask
    task automatic wait_done(input int who, output int steps);
        int found = 0;
        steps = 0;
        while (steps < 40 && found == 0) begin
            step();
            steps++;
            if (who == 0 ? bus.done0 : bus.done1) found = 1;
        end
        check("done_in_bound", 32'(found), 32'd1);
    endtask
    initial begin
        int k, t0, t1;
        {bus.req0, bus.req1} = 2'b00;
        {bus.a0, bus.b0, bus.a1, bus.b1} = '0;
        step();
        step();
        check("reset_sum", 32'(bus.sum), 32'd0);
        rst = 1'b1;
        // single request, carry into MSB
        bus.req0 = 1'b1; bus.a0 = 8'hFF; bus.b0 = 8'h01;
        step();
        wait_done(0, k);
        check("lat_030", 32'(k + 1), 32'd9);
        check("sum_030", 32'(bus.sum), 32'h100);
        bus.req0 = 1'b0;
        step();
        step();
        // simultaneous requests right after reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.req0 = 1'b1; bus.a0 = 8'd3; bus.b0 = 8'd4;
        bus.req1 = 1'b1; bus.a1 = 8'd200; bus.b1 = 8'd100;
        wait_done(0, k);
        t0 = cyc;
        check("sum_031a", 32'(bus.sum), 32'd7);
        bus.req0 = 1'b0;
        wait_done(1, k);
        t1 = cyc;
        check("sum_031b", 32'(bus.sum), 32'd300);
        check("gap_031", 32'(t1 - t0), 32'd10);
        bus.req1 = 1'b0;
        step();
        // operand change during SHIFT
        bus.req0 = 1'b1; bus.a0 = 8'h10; bus.b0 = 8'h20;
        step();
        bus.a0 = 8'hEE;
        wait_done(0, k);
        check("sum_033", 32'(bus.sum), 32'h030);
        bus.req0 = 1'b0;
        step();
        // reset on the 4th SHIFT cycle, then a fresh req1
        bus.req0 = 1'b1; bus.a0 = 8'h55; bus.b0 = 8'h66;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b1; bus.a1 = 8'h12; bus.b1 = 8'h34;
        step();
        check("gnt_034", 32'({bus.gnt0, bus.gnt1}), 32'd0);
        rst = 1'b1;
        step();
        check("gnt1_034", 32'(bus.gnt1), 32'd1);
        wait_done(1, k);
        check("sum_034", 32'(bus.sum), 32'h046);
        bus.req1 = 1'b0;
        step();
        // zero operands after a 0x1FE result
        bus.req0 = 1'b1; bus.a0 = 8'hFF; bus.b0 = 8'hFF;
        wait_done(0, k);
        check("sum_035a", 32'(bus.sum), 32'h1FE);
        bus.req0 = 1'b0; bus.req1 = 1'b1; bus.a1 = 8'd0; bus.b1 = 8'd0;
        wait_done(1, k);
        check("sum_035b", 32'(bus.sum), 32'd0);
        bus.req1 = 1'b0;
        // random traffic: back-to-back, mid-op drops, operand churn, sporadic reset
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            if (bus.req0 && (bus.done0 ? $urandom_range(0, 1) == 0 : $urandom_range(0, 29) == 0)) bus.req0 = 1'b0;
            else if (!bus.req0 && $urandom_range(0, 2) == 0) bus.req0 = 1'b1;
            if (bus.req1 && (bus.done1 ? $urandom_range(0, 1) == 0 : $urandom_range(0, 29) == 0)) bus.req1 = 1'b0;
            else if (!bus.req1 && $urandom_range(0, 2) == 0) bus.req1 = 1'b1;
            bus.a0 = 8'($urandom); bus.b0 = 8'($urandom);
            bus.a1 = 8'($urandom); bus.b1 = 8'($urandom);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_add_arbiter.md
SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; the sum is WIDTH+1 bits.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low: sampled on the clk rising edge, asserted when 0.
REQ-004 req0  input  1  requester 0 request; level, held until done0.
REQ-005 a0, b0  input  WIDTH each  requester 0 operands.
REQ-006 req1  input  1  requester 1 request; level, held until done1.
REQ-007 a1, b1  input  WIDTH each  requester 1 operands.
REQ-008 gnt0, gnt1  output  1 each  registered grant; at most one high at a time.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-010 sum  output  WIDTH+1  result of the last completed addition; carry-out in the MSB.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The block SHALL time-share one 1-bit full adder between both requesters, with a carry register and two operand shift registers shifting right (LSB first).
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE, any req high at an edge: select a winner, load its a/b into the shift registers, clear carry and the bit counter, set its gnt, go to SHIFT.
REQ-015 Arbitration SHALL be round-robin: a sole requester wins; if both request, the one not served last wins.
REQ-016 After reset, requester 0 SHALL have priority.
REQ-017 SHIFT, per edge: add the operand LSBs plus carry, shift the sum bit into the MSB of an internal WIDTH-bit result register, update carry, shift both operands, increment the counter.
REQ-018 SHIFT SHALL last exactly WIDTH cycles; on the WIDTH-th edge, load sum with {carry_out, result}, go to DONE.
REQ-019 DONE: the done output of the granted requester SHALL be high for exactly that one cycle; the next edge goes to IDLE and clears gnt.
REQ-020 Latency: gnt high for WIDTH+1 cycles; done is in the last of those cycles; sum is valid from the done cycle.
REQ-021 sum SHALL change only at completion (REQ-018) or reset; it holds between operations.
REQ-022 Operands SHALL be sampled only at the grant edge; later changes to a/b have no effect on the running operation.
REQ-023 req dropped mid-operation: the operation SHALL still complete and done SHALL still pulse; aborting is not supported.
REQ-024 req still high in IDLE after its done: it is a new request, arbitrated per REQ-015; there SHALL be no idle gap beyond the single IDLE cycle.
REQ-025 Arithmetic SHALL be unsigned modulo 2^(WIDTH+1); no overflow can occur.
REQ-026 Requests arriving during SHIFT or DONE SHALL be held off; they are not lost while the requester keeps req high.

Reset
REQ-027 With rst=0 at an edge: state SHALL be IDLE; gnt0, gnt1, done0, done1 and busy SHALL be 0; sum, carry, counter and shift registers SHALL be 0; the priority pointer SHALL favour requester 0.
REQ-028 Reset mid-operation SHALL abandon the operation with no done pulse, and sum SHALL read 0.
REQ-029 Reset SHALL override any simultaneous request.

Verification
REQ-030 Single request, req0 with a0=8'hFF, b0=8'h01 -> gnt0 for 9 cycles, done0 in the 9th, sum=9'h100.
REQ-031 req0 and req1 rise together after reset (a0=3, b0=4; a1=200, b1=100) -> requester 0 served first with sum=7, then requester 1 with sum=300; done0 precedes done1 by 10 cycles.
REQ-032 Both held high continuously -> grants alternate 0,1,0,1, each gnt window followed by one IDLE cycle.
REQ-033 a0 changed during SHIFT (loaded 8'h10, b0=8'h20) -> sum=9'h030, unaffected by the change.
REQ-034 rst=0 asserted on the 4th SHIFT cycle -> no done, sum=0, gnt=0; the next req1 is granted normally.
REQ-035 Zero operands, a1=b1=0 with a prior sum=9'h1FE -> sum holds 9'h1FE until the done1 cycle, then reads 0.
